dram_bridge: RTL and testbench

Bridges the DMA controller's 32-bit word DRAM request port to the 16-bit halfword command interface of the SDRAM memory controller. Each DMA word access becomes two sequential halfword commands, high half first. Write data is captured from the DMA port and read data is reassembled. The DMA sees a single completion pulse per word.

---
 rtl/dram_bridge.sv | 142 ++++++++++++++
 tb/tb_dram_bridge.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dram_bridge.sv
// dram_bridge: splits 32-bit DMA word reads/writes into two 16-bit SDRAM commands, high half first.
// Optional DRAM_BRIDGE_TIMEOUT_EN adds a per-state watchdog that aborts a stuck command with err.
module dram_bridge #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_req_read,
    input  logic        dma_req_write,
    output logic [31:0] dma_rdata,
    output logic        dma_data_valid,
    output logic        dma_write_complete,
    output logic [24:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, RD_HI, RD_HI_WAIT, RD_LO, RD_LO_WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic        wr_q, wr_d, err_q, err_d;
    logic        mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, dv_q, dv_d, wc_q, wc_d;
    logic [24:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        accept, lo;

`ifdef DRAM_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        err_d   = err_q;
        accept  = mem_ready && (mem_rd_q || mem_wr_q);
        case (state_q)
            IDLE: begin
                if (dma_req_write || dma_req_read) begin
                    state_d = dma_req_write ? WR_HI : RD_HI;
                    wr_d    = dma_req_write;
                    addr_d  = dma_addr;
                    wdata_d = dma_req_write ? dma_wdata : wdata_q;
                    err_d   = 1'b0;
                end
            end
            WR_HI:      state_d = accept ? WR_LO : WR_HI;
            WR_LO:      state_d = accept ? DONE : WR_LO;
            RD_HI:      state_d = accept ? RD_HI_WAIT : RD_HI;
            RD_LO:      state_d = accept ? RD_LO_WAIT : RD_LO;
            RD_HI_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d[31:16] = mem_rdata;
                    state_d        = RD_LO;
                end
            end
            RD_LO_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d[15:0] = mem_rdata;
                    state_d       = DONE;
                end
            end
            default:    state_d = IDLE;
        endcase
`ifdef DRAM_BRIDGE_TIMEOUT_EN
        // Abort only when the state made no progress for TIMEOUT consecutive cycles.
        if (state_q != IDLE && state_q != DONE && state_d == state_q && cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = wr_q ? rdata_q : 32'hDEADBEEF;
        end
        cnt_d = (state_d != state_q || state_q == IDLE || state_q == DONE) ? '0 : cnt_q + 1'b1;
`endif
        // Outputs are registered from the next state so they line up with it.
        lo          = (state_d == WR_LO) || (state_d == RD_LO);
        mem_rd_d    = (state_d == RD_HI) || (state_d == RD_LO);
        mem_wr_d    = (state_d == WR_HI) || (state_d == WR_LO);
        mem_addr_d  = {addr_d, lo};
        mem_wdata_d = lo ? wdata_d[15:0] : wdata_d[31:16];
        dv_d        = (state_d == DONE) && !wr_d;
        wc_d        = (state_d == DONE) && wr_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            dv_q        <= 1'b0;
            wc_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            dv_q        <= dv_d;
            wc_q        <= wc_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef DRAM_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`endif

    assign dma_rdata          = rdata_q;
    assign dma_data_valid     = dv_q;
    assign dma_write_complete = wc_q;
    assign mem_addr           = mem_addr_q;
    assign mem_wdata          = mem_wdata_q;
    assign mem_rd             = mem_rd_q;
    assign mem_wr             = mem_wr_q;
    assign err                = err_q;
endmodule

// File: tb/tb_dram_bridge.sv
// tb_dram_bridge: directed checks of dram_bridge word-to-halfword splitting, stalls and reset.
module tb_dram_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] dma_addr = '0;
    logic [31:0] dma_wdata = '0;
    logic        dma_req_read = 1'b0, dma_req_write = 1'b0;
    logic [31:0] dma_rdata;
    logic        dma_data_valid, dma_write_complete;
    logic [24:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd, mem_wr, err;
    logic        mem_ready = 1'b1;
    logic [15:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    int          errors = 0, checks = 0;

    dram_bridge #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_req_read(dma_req_read), .dma_req_write(dma_req_write),
        .dma_rdata(dma_rdata), .dma_data_valid(dma_data_valid),
        .dma_write_complete(dma_write_complete), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rdata"}, dma_rdata, 32'h0);
        chk({tag, "_dv"}, {31'b0, dma_data_valid}, 32'h0);
        chk({tag, "_wc"}, {31'b0, dma_write_complete}, 32'h0);
        chk({tag, "_maddr"}, {7'b0, mem_addr}, 32'h0);
        chk({tag, "_mwdata"}, {16'b0, mem_wdata}, 32'h0);
        chk({tag, "_mrd"}, {31'b0, mem_rd}, 32'h0);
        chk({tag, "_mwr"}, {31'b0, mem_wr}, 32'h0);
        chk({tag, "_err"}, {31'b0, err}, 32'h0);
    endtask

    initial begin
        tick();
        tick();
        chk_idle_outputs("reset");
        rst = 1'b1;
        tick();

        // basic write
        dma_addr = 24'h000010; dma_wdata = 32'h1234ABCD; dma_req_write = 1'b1;
        tick();
        chk("wr_c1_mwr", {31'b0, mem_wr}, 32'h1);
        chk("wr_c1_addr", {7'b0, mem_addr}, 32'h20);
        chk("wr_c1_data", {16'b0, mem_wdata}, 32'h1234);
        chk("wr_c1_wc", {31'b0, dma_write_complete}, 32'h0);
        tick();
        chk("wr_c2_mwr", {31'b0, mem_wr}, 32'h1);
        chk("wr_c2_addr", {7'b0, mem_addr}, 32'h21);
        chk("wr_c2_data", {16'b0, mem_wdata}, 32'hABCD);
        tick();
        chk("wr_c3_wc", {31'b0, dma_write_complete}, 32'h1);
        chk("wr_c3_mwr", {31'b0, mem_wr}, 32'h0);
        chk("wr_c3_dv", {31'b0, dma_data_valid}, 32'h0);
        dma_req_write = 1'b0;
        tick();
        chk("wr_c4_wc", {31'b0, dma_write_complete}, 32'h0);

        // basic read; rvalid also high during command states, which must be ignored
        dma_addr = 24'h000003; dma_req_read = 1'b1;
        tick();
        chk("rd_c1_mrd", {31'b0, mem_rd}, 32'h1);
        chk("rd_c1_addr", {7'b0, mem_addr}, 32'h6);
        mem_rvalid = 1'b1; mem_rdata = 16'h1111;
        tick();
        chk("rd_c2_mrd", {31'b0, mem_rd}, 32'h0);
        mem_rdata = 16'hCAFE;
        tick();
        chk("rd_c3_mrd", {31'b0, mem_rd}, 32'h1);
        chk("rd_c3_addr", {7'b0, mem_addr}, 32'h7);
        chk("rd_c3_rdata", dma_rdata, 32'hCAFE0000);
        mem_rdata = 16'h2222;
        tick();
        mem_rdata = 16'hF00D;
        tick();
        chk("rd_c5_dv", {31'b0, dma_data_valid}, 32'h1);
        chk("rd_c5_rdata", dma_rdata, 32'hCAFEF00D);
        chk("rd_c5_wc", {31'b0, dma_write_complete}, 32'h0);
        dma_req_read = 1'b0; mem_rvalid = 1'b0;
        tick();
        chk("rd_c6_dv", {31'b0, dma_data_valid}, 32'h0);
        chk("rd_c6_hold", dma_rdata, 32'hCAFEF00D);

        // simultaneous requests: write first, then read
        dma_addr = 24'h000040; dma_wdata = 32'h55AA66BB; dma_req_write = 1'b1; dma_req_read = 1'b1;
        tick();
        chk("sim_mwr", {31'b0, mem_wr}, 32'h1);
        chk("sim_mrd", {31'b0, mem_rd}, 32'h0);
        chk("sim_addr_hi", {7'b0, mem_addr}, 32'h80);
        chk("sim_data_hi", {16'b0, mem_wdata}, 32'h55AA);
        tick();
        chk("sim_addr_lo", {7'b0, mem_addr}, 32'h81);
        chk("sim_data_lo", {16'b0, mem_wdata}, 32'h66BB);
        tick();
        chk("sim_wc", {31'b0, dma_write_complete}, 32'h1);
        chk("sim_dv", {31'b0, dma_data_valid}, 32'h0);
        dma_req_write = 1'b0;
        tick();
        chk("sim_idle_mrd", {31'b0, mem_rd}, 32'h0);
        tick();
        chk("sim_rd_mrd", {31'b0, mem_rd}, 32'h1);
        chk("sim_rd_addr", {7'b0, mem_addr}, 32'h80);
        mem_rvalid = 1'b1; mem_rdata = 16'h1357;
        tick();
        tick();
        chk("sim_rd_lo_addr", {7'b0, mem_addr}, 32'h81);
        mem_rdata = 16'h2468;
        tick();
        tick();
        chk("sim_rd_dv", {31'b0, dma_data_valid}, 32'h1);
        chk("sim_rd_rdata", dma_rdata, 32'h13572468);
        dma_req_read = 1'b0; mem_rvalid = 1'b0;
        tick();

        // stalls: mem_ready low 5 cycles per command, completion at cycle 13
        dma_addr = 24'h123456; dma_wdata = 32'h0F0FA5A5; dma_req_write = 1'b1; mem_ready = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            tick();
            mem_ready = (c == 6 || c == 12);
            if (c <= 12) begin
                chk($sformatf("stall_c%0d_mwr", c), {31'b0, mem_wr}, 32'h1);
                chk($sformatf("stall_c%0d_addr", c), {7'b0, mem_addr}, (c <= 6) ? 32'h2468AC : 32'h2468AD);
                chk($sformatf("stall_c%0d_data", c), {16'b0, mem_wdata}, (c <= 6) ? 32'h0F0F : 32'hA5A5);
                chk($sformatf("stall_c%0d_wc", c), {31'b0, dma_write_complete}, 32'h0);
            end else begin
                chk("stall_c13_wc", {31'b0, dma_write_complete}, 32'h1);
                chk("stall_c13_mwr", {31'b0, mem_wr}, 32'h0);
            end
        end
        dma_req_write = 1'b0; mem_ready = 1'b1;
        tick();

        // reset while in RD_LO_WAIT
        dma_addr = 24'h000100; dma_req_read = 1'b1;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 16'hAAAA;
        tick();
        tick();
        mem_rvalid = 1'b0;
        tick();
        chk("rst_pre_rdata", dma_rdata, 32'hAAAA2468);
        rst = 1'b0;
        #1;
        chk_idle_outputs("rst_mid");
        tick();
        chk("rst_hold_dv", {31'b0, dma_data_valid}, 32'h0);
        rst = 1'b1;

        // new read after reset, at the top word address
        dma_addr = 24'hFFFFFF;
        tick();
        chk("post_mrd", {31'b0, mem_rd}, 32'h1);
        chk("post_addr_hi", {7'b0, mem_addr}, 32'h1FFFFFE);
        mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        tick();
        chk("post_addr_lo", {7'b0, mem_addr}, 32'h1FFFFFF);
        mem_rdata = 16'h1234;
        tick();
        tick();
        chk("post_dv", {31'b0, dma_data_valid}, 32'h1);
        chk("post_rdata", dma_rdata, 32'hBEEF1234);
        dma_req_read = 1'b0; mem_rvalid = 1'b0;
        tick();

`ifdef DRAM_BRIDGE_TIMEOUT_EN
        // timeout: no read beat ever arrives
        dma_addr = 24'h000020; dma_req_read = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk($sformatf("to_c%0d_err", c), {31'b0, err}, 32'h0);
            chk($sformatf("to_c%0d_dv", c), {31'b0, dma_data_valid}, 32'h0);
        end
        tick();
        chk("to_err", {31'b0, err}, 32'h1);
        chk("to_dv", {31'b0, dma_data_valid}, 32'h1);
        chk("to_rdata", dma_rdata, 32'hDEADBEEF);
        chk("to_mrd", {31'b0, mem_rd}, 32'h0);
        dma_req_read = 1'b0;
        tick();
        chk("to_err_sticky", {31'b0, err}, 32'h1);
        dma_req_write = 1'b1;
        tick();
        chk("to_err_clr", {31'b0, err}, 32'h0);
        tick();
        tick();
        chk("to_wc", {31'b0, dma_write_complete}, 32'h1);
        dma_req_write = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
